glyph_render: RTL
=================

GLYPH_RENDER -- requirements
Module: glyph_render

Interface
REQ-001 Parameter X0, default 288, left pixel column of the glyph box.
REQ-002 Parameter Y0, default 208, top pixel row of the glyph box.
REQ-003 Parameter SCALE_LOG2, default 3, log2 of the screen-pixel size of each glyph cell; box is (8<<SCALE_LOG2) square; X0/Y0 plus box size SHALL not exceed 1023.
REQ-004 clk  in  1  single system clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pix_en  in  1  one-cycle strobe per VGA pixel; all pipeline state advances only when high.
REQ-007 hcount  in  10  current pixel column.
REQ-008 vcount  in  10  current pixel row.
REQ-009 active  in  1  high inside the visible 640x480 region.
REQ-010 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-011 glyph  in  64  8x8 bitmap from the glyph ROM; row r = bits [63-8r : 56-8r], column c = bit (63-8r-c), MSB leftmost.
REQ-012 fg_color, bg_color  in  24 each  {R,G,B} 8 bits per channel.
REQ-013 hsync_in, vsync_in, blank_n_in  in  1 each  timing signals aligned with hcount/vcount.
REQ-014 r, g, b  out  8 each  pixel colour.
REQ-015 hsync_out, vsync_out, blank_n_out  out  1 each  timing signals realigned with r/g/b.

Function
REQ-016 Glyph SHALL be captured into a shadow register on any clk edge with frame_start high; glyph changes between frame_start pulses SHALL have no visible effect.
REQ-017 Stage 1 (on pix_en): register in_box = (X0 <= hcount < X0+(8<<SCALE_LOG2)) and (Y0 <= vcount < Y0+(8<<SCALE_LOG2)); col = (hcount-X0)>>SCALE_LOG2, row = (vcount-Y0)>>SCALE_LOG2, 3 bits each; register active and the three timing inputs.
REQ-018 Stage 2 (on pix_en): register colour: not active -> 0; active and not in_box -> bg_color; in_box and shadow bit(row,col)=1 -> fg_color; else bg_color; timing signals delayed alongside.
REQ-019 Latency SHALL be exactly 2 pix_en strobes from hcount/vcount/timing inputs to r/g/b and *_out; all outputs share identical delay.
REQ-020 With pix_en low, every pipeline register and all outputs SHALL hold.
REQ-021 frame_start and pix_en in the same cycle: stage 2 uses the pre-update shadow; new glyph takes effect from the next pix_en.
REQ-022 Box edges: hcount = X0+(8<<SCALE_LOG2)-1 is inside; hcount = X0+(8<<SCALE_LOG2) is outside; hcount = X0-1 is outside (no wrap from unsigned subtraction; compare precedes subtract).
REQ-023 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 While rst high: r/g/b = 0, hsync_out = 1, vsync_out = 1, blank_n_out = 0, shadow glyph = 0, all pipeline stages cleared, regardless of pix_en.
REQ-025 Reset mid-frame: outputs take reset values at the next clk edge; after release the pipeline refills in 2 pix_en strobes and the glyph renders as background until the next frame_start.

Verification
REQ-026 Reset: rst=1 for 3 clocks with pix_en toggling -> r=g=b=0, hsync_out=vsync_out=1, blank_n_out=0 throughout.
REQ-027 Glyph 64'h0038444444444438 loaded via frame_start, fg=24'hFFFFFF, bg=24'h000080; hcount=304, vcount=216, active=1 -> after 2 pix_en, {r,g,b}=24'hFFFFFF; hcount=288, vcount=216 -> 24'h000080.
REQ-028 Edges with defaults: hcount=351/vcount=271 inside (bit row7 col7), hcount=352 -> bg_color, hcount=287 -> bg_color, active=0 -> 0.
REQ-029 Tear-free: change glyph mid-frame without frame_start -> pixels unchanged; pulse frame_start -> new bitmap on next frame.
REQ-030 Stall: hold pix_en low 10 clocks with changing hcount -> outputs constant; latency re-measured as 2 strobes after resumption, hsync_out/vsync_out delayed by exactly 2 strobes.
REQ-031 Reset mid-frame at hcount=320 -> outputs reset next edge; after release, box pixels show bg_color until frame_start.

Source files
------------

// File: rtl/glyph_render.sv
// Overlays one 8x8 glyph, scaled by 2**SCALE_LOG2, onto a VGA pixel stream.
// Two pix_en-gated register stages; the glyph is double-buffered per frame.
module glyph_render #(
    parameter int X0         = 288,
    parameter int Y0         = 208,
    parameter int SCALE_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        active,
    input  logic        frame_start,
    input  logic [63:0] glyph,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_n_in,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_n_out
);

    localparam int BOX = 8 << SCALE_LOG2;
    localparam logic [10:0] XL = 11'(X0);
    localparam logic [10:0] XH = 11'(X0 + BOX);
    localparam logic [10:0] YL = 11'(Y0);
    localparam logic [10:0] YH = 11'(Y0 + BOX);

    logic [63:0] shadow;

    logic        s1_inbox;
    logic        s1_active;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_bn;
    logic [2:0]  s1_col;
    logic [2:0]  s1_row;

    logic [23:0] s2_rgb;
    logic        s2_hs;
    logic        s2_vs;
    logic        s2_bn;

    logic        h_in;
    logic        v_in;
    logic        inbox_c;
    logic [9:0]  hoff;
    logic [9:0]  voff;
    logic [2:0]  col_c;
    logic [2:0]  row_c;
    logic        pix_on;
    logic [23:0] rgb_c;

    // Range test is done at 11 bits before subtracting, so columns left of X0 never wrap in.
    always_comb begin
        h_in    = ({1'b0, hcount} >= XL) && ({1'b0, hcount} < XH);
        v_in    = ({1'b0, vcount} >= YL) && ({1'b0, vcount} < YH);
        inbox_c = h_in && v_in;
        hoff    = hcount - XL[9:0];
        voff    = vcount - YL[9:0];
        col_c   = '0;
        row_c   = '0;
        if (inbox_c) begin
            col_c = 3'(hoff >> SCALE_LOG2);
            row_c = 3'(voff >> SCALE_LOG2);
        end
    end

    // Bit (63 - 8*row - col): row-major with the MSB as the top-left cell.
    always_comb begin
        pix_on = shadow[6'd63 - {s1_row, s1_col}];
        rgb_c  = bg_color;
        if (!s1_active) begin
            rgb_c = '0;
        end else if (s1_inbox && pix_on) begin
            rgb_c = fg_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_start) begin
            shadow <= glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_inbox  <= 1'b0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_bn     <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
        end else if (pix_en) begin
            s1_inbox  <= inbox_c;
            s1_active <= active;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            s1_bn     <= blank_n_in;
            s1_col    <= col_c;
            s1_row    <= row_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rgb <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
            s2_bn  <= 1'b0;
        end else if (pix_en) begin
            s2_rgb <= rgb_c;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_bn  <= s1_bn;
        end
    end

    assign r           = s2_rgb[23:16];
    assign g           = s2_rgb[15:8];
    assign b           = s2_rgb[7:0];
    assign hsync_out   = s2_hs;
    assign vsync_out   = s2_vs;
    assign blank_n_out = s2_bn;

endmodule
